procyon_retire_trace: RTL

// - Debug capture stage downstream of the core's retire port on the FPGA test top. Buffers every

---
 rtl/procyon_trace_pkg.sv | 24 ++
 rtl/procyon_retire_trace_if.sv | 29 ++
 rtl/procyon_trace_fifo.sv | 65 ++++++
 rtl/procyon_retire_trace.sv | 97 +++++++++
 4 files changed

// File: rtl/procyon_trace_pkg.sv
// Shared types and defaults for the retire-trace capture slice.
// The entry layout, display states and default sizing live here.
package procyon_trace_pkg;

  localparam int TRACE_DATA_WIDTH  = 32;
  localparam int TRACE_IDX_WIDTH   = 5;
  localparam int TRACE_DEPTH       = 16;
  localparam int TRACE_HALT_MARGIN = 2;

  typedef struct packed {
    logic [TRACE_IDX_WIDTH-1:0]  rdest;
    logic [TRACE_DATA_WIDTH-1:0] data;
  } trace_entry_t;

  typedef enum logic {
    DISP_NONE = 1'b0,
    DISP_SHOW = 1'b1
  } disp_state_t;

  function automatic int trace_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/procyon_retire_trace_if.sv
// Retire/step/clear inputs and display/status outputs of the trace stage.
// The master side drives the retire port and keys; the slave side is the trace stage.
interface procyon_retire_trace_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5,
  parameter int CNT_W  = 5
);
  logic              i_retire_en;
  logic [IDX_W-1:0]  i_retire_rdest;
  logic [DATA_W-1:0] i_retire_data;
  logic              i_step;
  logic              i_clear;
  logic              o_disp_valid;
  logic [IDX_W-1:0]  o_disp_rdest;
  logic [DATA_W-1:0] o_disp_data;
  logic [CNT_W-1:0]  o_count;
  logic              o_halt;
  logic              o_overflow;

  modport master (
    output i_retire_en, i_retire_rdest, i_retire_data, i_step, i_clear,
    input  o_disp_valid, o_disp_rdest, o_disp_data, o_count, o_halt, o_overflow
  );

  modport slave (
    input  i_retire_en, i_retire_rdest, i_retire_data, i_step, i_clear,
    output o_disp_valid, o_disp_rdest, o_disp_data, o_count, o_halt, o_overflow
  );
endinterface

// File: rtl/procyon_trace_fifo.sv
// Synchronous FIFO, no bypass: a pushed entry is poppable the cycle after; flush beats push/pop.
// Push refused only when full without a same-cycle pop; pop refused when empty.
module procyon_trace_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     count_nxt,
  output logic                       full,
  output logic                       empty,
  output logic                       push_acc,
  output logic                       pop_acc
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_dat = mem[rd_ptr_q];

  // A pop frees the slot in the same edge, so a full FIFO still accepts a push alongside it.
  assign pop_acc  = pop && !empty && !flush;
  assign push_acc = push && (!full || pop_acc) && !flush;

  always_comb begin
    count_nxt = count_q;
    if (flush) begin
      count_nxt = '0;
    end else if (push_acc && !pop_acc) begin
      count_nxt = count_q + CNT_W'(1);
    end else if (pop_acc && !push_acc) begin
      count_nxt = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_nxt;
      if (push_acc) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_acc)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/procyon_retire_trace.sv
// Retire-trace capture: FIFO of retired writes, step pops one into a held display (1 cycle).
// Registered halt request near full; retires into a full FIFO without a pop set a sticky overflow.
module procyon_retire_trace
  import procyon_trace_pkg::*;
#(
  parameter int OPTN_DATA_WIDTH       = TRACE_DATA_WIDTH,
  parameter int OPTN_REGMAP_IDX_WIDTH = TRACE_IDX_WIDTH,
  parameter int OPTN_TRACE_DEPTH      = TRACE_DEPTH,
  parameter int OPTN_HALT_MARGIN      = TRACE_HALT_MARGIN
) (
  input logic                   clk,
  input logic                   rst,
  procyon_retire_trace_if.slave trace
);
  localparam int ENTRY_W = OPTN_REGMAP_IDX_WIDTH + OPTN_DATA_WIDTH;
  localparam int CNT_W   = $clog2(OPTN_TRACE_DEPTH) + 1;
  localparam logic [CNT_W-1:0] HALT_THRESH = CNT_W'(OPTN_TRACE_DEPTH - OPTN_HALT_MARGIN);

  logic [ENTRY_W-1:0]               head_dat;
  logic [CNT_W-1:0]                 count;
  logic [CNT_W-1:0]                 count_nxt;
  logic                             full;
  logic                             empty;
  logic                             push_acc;
  logic                             pop_acc;
  disp_state_t                      state_q;
  disp_state_t                      state_d;
  logic [OPTN_REGMAP_IDX_WIDTH-1:0] disp_rdest_q;
  logic [OPTN_DATA_WIDTH-1:0]       disp_data_q;
  logic                             overflow_q;
  logic                             halt_q;

  procyon_trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (OPTN_TRACE_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (trace.i_clear),
    .push      (trace.i_retire_en),
    .push_dat  ({trace.i_retire_rdest, trace.i_retire_data}),
    .pop       (trace.i_step),
    .head_dat  (head_dat),
    .count     (count),
    .count_nxt (count_nxt),
    .full      (full),
    .empty     (empty),
    .push_acc  (push_acc),
    .pop_acc   (pop_acc)
  );

  always_comb begin
    state_d = state_q;
    if (trace.i_clear) begin
      state_d = DISP_NONE;
    end else if (pop_acc) begin
      state_d = DISP_SHOW;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= DISP_NONE;
    else     state_q <= state_d;
  end

  // Display holds its last popped entry across steps on an empty FIFO.
  always_ff @(posedge clk) begin
    if (rst || trace.i_clear) begin
      disp_rdest_q <= '0;
      disp_data_q  <= '0;
    end else if (pop_acc) begin
      {disp_rdest_q, disp_data_q} <= head_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || trace.i_clear) begin
      overflow_q <= 1'b0;
    end else if (trace.i_retire_en && !push_acc) begin
      overflow_q <= 1'b1;
    end
  end

  // Halt tracks the post-edge occupancy so it rises the cycle after the threshold push.
  always_ff @(posedge clk) begin
    if (rst) halt_q <= 1'b0;
    else     halt_q <= (count_nxt >= HALT_THRESH);
  end

  assign trace.o_disp_valid = (state_q == DISP_SHOW);
  assign trace.o_disp_rdest = disp_rdest_q;
  assign trace.o_disp_data  = disp_data_q;
  assign trace.o_count      = count;
  assign trace.o_halt       = halt_q;
  assign trace.o_overflow   = overflow_q;

endmodule
